// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset/bring-up sequencer: state encoding,
// default parameter values and a saturating-increment helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int DEF_NUM_CH         = 3;
  localparam int DEF_HOLD_CYCLES    = 25;
  localparam int DEF_STAGGER_CYCLES = 2;
  localparam int DEF_WDOG_CYCLES    = 1024;
  localparam int DEF_CNT_W          = 32;

  // Callers zero-extend to 64 bits and pass their own all-ones ceiling.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    return (value == max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/rst_seq_wdog.sv
// Watchdog counter for rst_sequencer; the module only exists when
// RST_SEQ_WDOG_EN is defined.
`ifdef RST_SEQ_WDOG_EN
module rst_seq_wdog
  import rst_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic clk_in,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk_in) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= CNT_W'(sat_inc(64'(count), 64'(CNT_MAX)));
    end
  end

  // A heartbeat arrives through clear, so it beats expiry on the same edge.
  assign expire = enable && !clear && (count == LAST);

endmodule
`endif

// File: rtl/rst_sequencer.sv
// Reset stretcher and staggered per-channel release with run-cycle counter.
// Define RST_SEQ_WDOG_EN to build in the heartbeat watchdog and TIMEOUT state.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int WDOG_CYCLES    = DEF_WDOG_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              soft_rst_req,
  input  logic              heartbeat,
  output logic [NUM_CH-1:0] rst_out,
  output logic              all_released,
  output logic              wdog_timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((NUM_CH - 1) * STAGGER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam bit               DIRECT    = (NUM_CH == 1) || (STAGGER_CYCLES == 0);

  state_e            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [NUM_CH-1:0] rst_out_d;
  logic              all_released_d;
  logic              wdog_timeout_d;
  logic [CNT_W-1:0]  cycle_count_d;
  logic              wdog_expire;

`ifdef RST_SEQ_WDOG_EN
  rst_seq_wdog #(
    .CNT_W       (CNT_W),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk_in (clk_in),
    .clear  (rst_in | soft_rst_req | heartbeat | (state != ST_RUN)),
    .enable (state == ST_RUN),
    .expire (wdog_expire)
  );
`else
  logic unused_wdog;
  assign unused_wdog = heartbeat ^ (WDOG_CYCLES == 0);
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_HOLD;
      cnt          <= '0;
      rst_out      <= '1;
      all_released <= 1'b0;
      wdog_timeout <= 1'b0;
      cycle_count  <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      rst_out      <= rst_out_d;
      all_released <= all_released_d;
      wdog_timeout <= wdog_timeout_d;
      cycle_count  <= cycle_count_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    state_d        = state;
    cnt_d          = cnt;
    rst_out_d      = rst_out;
    all_released_d = all_released;
    wdog_timeout_d = wdog_timeout;
    cycle_count_d  = cycle_count;

    if (soft_rst_req) begin
      state_d        = ST_HOLD;
      cnt_d          = '0;
      rst_out_d      = '1;
      all_released_d = 1'b0;
      cycle_count_d  = '0;
    end else if (wdog_expire) begin
      state_d        = ST_TIMEOUT;
      rst_out_d      = '1;
      all_released_d = 1'b0;
      wdog_timeout_d = 1'b1;
    end else begin
      unique case (state)
        ST_HOLD: begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == HOLD_LAST) begin
            cnt_d = '0;
            if (DIRECT) begin
              state_d        = ST_RUN;
              rst_out_d      = '0;
              all_released_d = 1'b1;
              cycle_count_d  = '0;
            end else begin
              state_d      = ST_STAGGER;
              rst_out_d[0] = 1'b0;
            end
          end
        end
        ST_STAGGER: begin
          // cnt_d is the number of edges since channel 0 was released.
          cnt_d = cnt + CNT_W'(1);
          for (int k = 1; k < NUM_CH; k++) begin
            if (cnt_d == CNT_W'(k * STAGGER_CYCLES)) rst_out_d[k] = 1'b0;
          end
          if (cnt_d == STAG_LAST) begin
            state_d        = ST_RUN;
            cnt_d          = '0;
            all_released_d = 1'b1;
            cycle_count_d  = '0;
          end
        end
        ST_RUN: begin
          cycle_count_d = CNT_W'(sat_inc(64'(cycle_count), 64'(CNT_MAX)));
        end
        ST_TIMEOUT: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with a time-stamped scoreboard; expectations
// follow RST_SEQ_WDOG_EN so the same bench serves both builds.
module tb_rst_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in, soft_rst_req, heartbeat;
  logic [2:0]  rst_out;
  logic        all_released, wdog_timeout;
  logic [31:0] cycle_count;

  logic        rst_z, soft_z, hb_z;
  logic [2:0]  rst_out_z;
  logic        all_released_z, wdog_timeout_z;
  logic [7:0]  cycle_count_z;

  always #5 clk_in = ~clk_in;

  rst_sequencer #(
    .NUM_CH(3), .HOLD_CYCLES(25), .STAGGER_CYCLES(2), .WDOG_CYCLES(16), .CNT_W(32)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .soft_rst_req (soft_rst_req),
    .heartbeat    (heartbeat),
    .rst_out      (rst_out),
    .all_released (all_released),
    .wdog_timeout (wdog_timeout),
    .cycle_count  (cycle_count)
  );

  // Zero-stagger, narrow-counter instance: simultaneous release and saturation.
  rst_sequencer #(
    .NUM_CH(3), .HOLD_CYCLES(25), .STAGGER_CYCLES(0), .WDOG_CYCLES(16), .CNT_W(8)
  ) dut_z (
    .clk_in       (clk_in),
    .rst_in       (rst_z),
    .soft_rst_req (soft_z),
    .heartbeat    (hb_z),
    .rst_out      (rst_out_z),
    .all_released (all_released_z),
    .wdog_timeout (wdog_timeout_z),
    .cycle_count  (cycle_count_z)
  );

  typedef struct {
    int unsigned at;
    string       tag;
    bit          z;
    logic [2:0]  ro;
    logic        ar;
    logic        wd;
    logic [31:0] cc;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_no  = 0;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic push(input int unsigned at, input string tag, input bit z,
                      input logic [2:0] ro, input logic ar, input logic wd,
                      input logic [31:0] cc);
    exp_t e;
    int   i;
    e = '{at: at, tag: tag, z: z, ro: ro, ar: ar, wd: wd, cc: cc};
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  task automatic check_due();
    exp_t        e;
    logic [2:0]  ro;
    logic        ar, wd;
    logic [31:0] cc;
    while (sb.size() > 0 && sb[0].at <= edge_no) begin
      e  = sb.pop_front();
      ro = e.z ? rst_out_z      : rst_out;
      ar = e.z ? all_released_z : all_released;
      wd = e.z ? wdog_timeout_z : wdog_timeout;
      cc = e.z ? 32'(cycle_count_z) : cycle_count;
      n_assert++;
      assert (e.at == edge_no && {ro, ar, wd, cc} === {e.ro, e.ar, e.wd, e.cc}) else begin
        n_fail++;
        $error("FAIL %s @edge %0d: observed rst_out=%b all_rel=%b wdog=%b cnt=%0d, expected rst_out=%b all_rel=%b wdog=%b cnt=%0d (due edge %0d)",
               e.tag, edge_no, ro, ar, wd, cc, e.ro, e.ar, e.wd, e.cc, e.at);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    edge_no++;
    check_due();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int unsigned base, rel, b2, b3, r3, guard;
`ifdef RST_SEQ_WDOG_EN
    int unsigned b4;
`endif
    rst_in = 1'b1; soft_rst_req = 1'b0; heartbeat = 1'b0;
    rst_z  = 1'b1; soft_z = 1'b0; hb_z = 1'b1;

    push(5, "reset", 0, 3'b111, 0, 0, 0);
    push(5, "reset_z", 1, 3'b111, 0, 0, 0);
    run(5);

    // Bring-up: edge 1 is the first edge sampling rst_in=0.
    rst_in = 1'b0; rst_z = 1'b0;
    base = edge_no;
    push(base + 24, "hold_end", 0, 3'b111, 0, 0, 0);
    push(base + 25, "ch0_rel", 0, 3'b110, 0, 0, 0);
    push(base + 26, "ch0_only", 0, 3'b110, 0, 0, 0);
    push(base + 27, "ch1_rel", 0, 3'b100, 0, 0, 0);
    push(base + 28, "ch1_only", 0, 3'b100, 0, 0, 0);
    push(base + 29, "all_rel", 0, 3'b000, 1, 0, 0);
    push(base + 24, "z_hold_end", 1, 3'b111, 0, 0, 0);
    push(base + 25, "z_all_rel", 1, 3'b000, 1, 0, 0);
    push(base + 100, "z_run", 1, 3'b000, 1, 0, 75);
    push(base + 279, "z_pre_sat", 1, 3'b000, 1, 0, 254);
    push(base + 280, "z_sat", 1, 3'b000, 1, 0, 255);
    push(base + 400, "z_sat_hold", 1, 3'b000, 1, 0, 255);
    run(29);
    rel = edge_no;

    // Heartbeat on every 10th edge keeps the watchdog quiet.
    push(rel + 50, "run50", 0, 3'b000, 1, 0, 50);
    push(rel + 100, "run100", 0, 3'b000, 1, 0, 100);
    for (int i = 1; i <= 100; i++) begin
      heartbeat = (i % 10 == 0);
      tick();
    end
    heartbeat = 1'b0;

`ifdef RST_SEQ_WDOG_EN
    push(rel + 115, "pre_expiry", 0, 3'b000, 1, 0, 115);
    push(rel + 116, "expiry", 0, 3'b111, 0, 1, 115);
    push(rel + 166, "timeout_hold", 0, 3'b111, 0, 1, 115);
`else
    push(rel + 116, "no_expiry", 0, 3'b000, 1, 0, 116);
    push(rel + 166, "no_expiry_late", 0, 3'b000, 1, 0, 166);
`endif
    run(66);

    // rst_in clears everything, including the sticky flag.
    rst_in = 1'b1;
    push(edge_no + 2, "rst_clear", 0, 3'b111, 0, 0, 0);
    run(2);
    rst_in = 1'b0;
    b2 = edge_no;
    push(b2 + 25, "rb_ch0_rel", 0, 3'b110, 0, 0, 0);
    run(25);

    // One-edge soft request during STAGGER restarts the whole sequence.
    soft_rst_req = 1'b1;
    push(b2 + 26, "soft_stagger", 0, 3'b111, 0, 0, 0);
    tick();
    soft_rst_req = 1'b0;
    b3 = edge_no;
    push(b3 + 24, "soft_hold_end", 0, 3'b111, 0, 0, 0);
    push(b3 + 25, "soft_ch0_rel", 0, 3'b110, 0, 0, 0);
    push(b3 + 27, "soft_ch1_rel", 0, 3'b100, 0, 0, 0);
    push(b3 + 29, "soft_all_rel", 0, 3'b000, 1, 0, 0);
    run(29);
    r3 = edge_no;

`ifdef RST_SEQ_WDOG_EN
    // Straight after release with no heartbeat, then soft request keeps the flag.
    push(r3 + 15, "pre_expiry2", 0, 3'b000, 1, 0, 15);
    push(r3 + 16, "expiry2", 0, 3'b111, 0, 1, 15);
    run(16);
    soft_rst_req = 1'b1;
    push(edge_no + 1, "soft_timeout", 0, 3'b111, 0, 1, 0);
    tick();
    soft_rst_req = 1'b0;
    b4 = edge_no;
    push(b4 + 25, "sticky_ch0_rel", 0, 3'b110, 0, 1, 0);
    push(b4 + 29, "sticky_all_rel", 0, 3'b000, 1, 1, 0);
    run(29);
`else
    push(r3 + 2000, "long_run", 0, 3'b000, 1, 0, 2000);
    run(2000);
`endif

    guard = 0;
    while (sb.size() > 0 && guard < 1000) begin
      tick();
      guard++;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_assert++;
      n_fail++;
      $display("FAIL %s: never reached, observed edge %0d, required edge %0d", e.tag, edge_no, e.at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset/bring-up sequencer between the board clock/reset pins and the CPU core, memory controller and UART. It stretches the external reset to a fixed hold, releases N reset channels in a staggered order, and counts run cycles. An optional watchdog re-asserts all resets when the core stops reporting activity. In simulation builds it replaces the fixed 25-cycle reset hold used on the bench.

## Interface
- NUM_CH, 3: number of reset channels; must be ≥1.
- HOLD_CYCLES, 25: clock edges with rst_in low before channel 0 is released; must be ≥1.
- STAGGER_CYCLES, 2: edges between consecutive channel releases; 0 releases all channels together.
- WDOG_CYCLES, 1024: edges without heartbeat before the watchdog fires; must be ≥1.
- CNT_W, 32: width of the run-cycle counter and of all internal counters.
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  synchronous, active-high reset (board button); sampled on clk_in.
- soft_rst_req  input  1  level request to restart the bring-up sequence (debug/UART).
- heartbeat  input  1  activity pulse from the core; clears the watchdog.
- rst_out  output  NUM_CH  per-channel active-high reset; channel 0 is released first.
- all_released  output  1  high while every channel is released.
- wdog_timeout  output  1  sticky watchdog-fired flag.
- cycle_count  output  CNT_W  edges elapsed since the final release; saturates.

## Operation
- States: HOLD, STAGGER, RUN, TIMEOUT.
- Priority at each edge: rst_in, then soft_rst_req, then watchdog expiry, then normal progress.
- rst_in=1: state HOLD and all counters 0.
  - Reset values: rst_out all 1s, all_released 0, wdog_timeout 0, cycle_count 0.
- soft_rst_req=1 with rst_in=0, in any state: behaves like rst_in, except wdog_timeout keeps its value.
- HOLD: the hold counter increments on every edge. On the HOLD_CYCLES-th edge the block goes to STAGGER and clears rst_out[0] on that same edge.
- STAGGER: rst_out[k] clears k*STAGGER_CYCLES edges after rst_out[0] clears.
  - On the edge rst_out[NUM_CH-1] clears, the block goes to RUN and all_released rises.
  - With NUM_CH=1 or STAGGER_CYCLES=0, the block goes from HOLD directly to RUN.
- RUN: cycle_count is 0 on the release edge, then +1 per edge. It saturates at all-ones; there is no wrap-around.
- Released channels never re-assert except through rst_in, soft_rst_req or TIMEOUT.
- TIMEOUT: rst_out all 1s, all_released 0 and wdog_timeout 1; cycle_count is frozen. Only rst_in or soft_rst_req leave this state, and both go to HOLD.

## Timing
- All outputs are registered. Every change appears at the edge that causes it, with no combinational path from inputs to outputs.
- Release latency from the first edge sampling rst_in=0 (counted as edge 1):
  - rst_out[k] clears at edge HOLD_CYCLES + k*STAGGER_CYCLES.
  - all_released rises at edge HOLD_CYCLES + (NUM_CH-1)*STAGGER_CYCLES.
- Watchdog counter:
  - Cleared on the release edge and on every edge that samples heartbeat=1.
  - Active only in RUN.
  - Expiry: the WDOG_CYCLES-th consecutive edge without heartbeat moves the block to TIMEOUT on that edge.
  - heartbeat on the expiry edge wins; no timeout.
- A soft_rst_req lasting several edges holds the block in HOLD with its counter at 0. The hold count starts on the first edge sampling soft_rst_req=0.

## Configuration
- RST_SEQ_WDOG_EN defined: the watchdog counter and the TIMEOUT state are compiled in, as described above.
- RST_SEQ_WDOG_EN undefined:
  - No watchdog logic; heartbeat is ignored.
  - wdog_timeout is tied to 0 and TIMEOUT is unreachable.
  - RUN persists until rst_in or soft_rst_req.

## Structure
- Shared package rst_seq_pkg holds:
  - the 2-bit state encoding: HOLD=0, STAGGER=1, RUN=2, TIMEOUT=3;
  - the default parameter values;
  - a saturating-increment function.
- Sub-module rst_seq_wdog: the CNT_W watchdog counter with clear, enable and expire outputs. It is instantiated only under RST_SEQ_WDOG_EN.

## Test plan
All scenarios use NUM_CH=3, HOLD_CYCLES=25, STAGGER_CYCLES=2, WDOG_CYCLES=16 unless a scenario says otherwise.
- Bring-up: rst_in high 5 cycles then low -> rst_out goes 111→110 at edge 25, →100 at edge 27, →000 at edge 29; all_released rises at edge 29.
- Heartbeat every 10 edges for 100 edges after release -> wdog_timeout stays 0 and cycle_count=100.
- No heartbeat after release -> at the 16th edge after release, wdog_timeout=1, rst_out=111, all_released=0; the state holds for 50 further edges.
- soft_rst_req for 1 edge at edge 26, during STAGGER -> rst_out=111 next edge; the release sequence repeats with rst_out[0] clearing 25 edges after the request drops.
- rst_in during TIMEOUT -> wdog_timeout returns to 0; a full bring-up follows.
- STAGGER_CYCLES=0 build, and a build without RST_SEQ_WDOG_EN -> all channels release at edge 25; with no heartbeat, no timeout occurs for 2000 edges.
